// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the program loader.
package prog_loader_pkg;

    // Defaults match the CPU's 32x8 instruction/data memory.
    localparam int unsigned AwDefault    = 5;
    localparam int unsigned DwDefault    = 8;
    localparam logic [7:0]  MagicDefault = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCheck,
        StRun
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready byte stream from the host byte source into the loader.
interface prog_loader_if #(
    parameter int unsigned DW = 8
) ();
    logic [DW-1:0] i_byte;
    logic          i_valid;
    logic          o_ready;

    modport master (
        output i_byte,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_byte,
        input  i_valid,
        output o_ready
    );
endinterface

// File: rtl/checksum_acc.sv
// XOR accumulator for the frame checksum; clear has priority over enable.
module checksum_acc #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // Accumulate one byte per enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes the image to memory, verifies the XOR
// checksum, then releases the CPU until it halts.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned   AW    = AwDefault,
    parameter int unsigned   DW    = DwDefault,
    parameter logic [DW-1:0] MAGIC = DW'(MagicDefault)
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  host,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_data,
    output logic          o_mem_wr,
    output logic          o_cpu_run,
    input  logic          i_cpu_halt,
    output logic          o_busy,
    output logic          o_err,
    output logic          o_done,
    output logic [AW:0]   o_count
);

    state_e        state_q;
    logic          ready_q;
    logic [AW:0]   len_q;
    logic [DW-1:0] acc_q;
    logic          xfer;
    logic          acc_clr;
    logic          acc_en;
    logic [31:0]   len_ext;
    logic          len_bad;
    logic [AW:0]   count_inc;

    assign host.o_ready = ready_q;
    assign xfer         = host.i_valid && ready_q;
    assign acc_clr      = xfer && (state_q == StIdle) && (host.i_byte == MAGIC);
    assign acc_en       = xfer && (state_q == StData);
    assign len_ext      = 32'(host.i_byte);
    assign len_bad      = (len_ext == 32'd0) || (len_ext > (32'd1 << AW));
    assign count_inc    = o_count + {{AW{1'b0}}, 1'b1};

    checksum_acc #(
        .DW (DW)
    ) u_checksum_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (host.i_byte),
        .q   (acc_q)
    );

    // Frame FSM with all outputs registered; ready is 0 in RUN and for the
    // cycle after the halt exit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            len_q      <= '0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            o_mem_wr   <= 1'b0;
            o_cpu_run  <= 1'b0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_done     <= 1'b0;
            o_count    <= '0;
        end else begin
            o_mem_wr <= 1'b0;
            o_done   <= 1'b0;
            case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (xfer && host.i_byte == MAGIC) begin
                        state_q <= StLen;
                        o_err   <= 1'b0;
                        o_count <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                StLen: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state_q <= StIdle;
                            o_err   <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            state_q <= StData;
                            len_q   <= len_ext[AW:0];
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        o_mem_wr   <= 1'b1;
                        o_mem_addr <= o_count[AW-1:0];
                        o_mem_data <= host.i_byte;
                        o_count    <= count_inc;
                        if (count_inc == len_q) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (xfer) begin
                        o_busy <= 1'b0;
                        if (host.i_byte == acc_q) begin
                            state_q   <= StRun;
                            o_cpu_run <= 1'b1;
                            ready_q   <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            o_err   <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (i_cpu_halt) begin
                        state_q   <= StIdle;
                        o_cpu_run <= 1'b0;
                        o_done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the 8-bit accumulator CPU. It accepts a framed program image over a valid/ready byte interface, writes it into the 32x8 instruction/data memory through the memory write port, and verifies a checksum. On success it releases the CPU from reset, then holds the CPU in reset again once the CPU halts. It is the writer side of the memory that the CPU fetches from, and sits between the host byte source and the CPU/memory top level.

## Interface
Parameters:
- AW, 5: memory address width; image holds up to 2^AW bytes
- DW, 8: data/byte width
- MAGIC, 8'hA5: frame start byte

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_byte  in  DW  incoming stream byte
- i_valid  in  1  i_byte valid
- o_ready  out  1  loader can accept a byte; a transfer occurs when i_valid && o_ready on a rising edge
- o_mem_addr  out  AW  memory write address
- o_mem_data  out  DW  memory write data
- o_mem_wr  out  1  one-cycle memory write strobe
- o_cpu_run  out  1  1 = CPU released; the top level drives CPU rst = ~o_cpu_run
- i_cpu_halt  in  1  CPU halt flag
- o_busy  out  1  frame in progress (LEN, DATA, CHECK)
- o_err  out  1  sticky frame error
- o_done  out  1  one-cycle pulse when a run ends on halt
- o_count  out  AW+1  bytes written in the current/last frame

## Operation
- Frame format: MAGIC, L, D0..D(L-1), C.
  - L ranges 1..2^AW.
  - Di is written to address i.
  - C = XOR of D0..D(L-1).
- FSM states: IDLE, LEN, DATA, CHECK, RUN.
- IDLE: o_ready=1.
  - MAGIC accepted -> LEN; clears o_err, o_count and the checksum accumulator.
  - Any other byte is consumed and discarded.
- LEN: accept L.
  - L==0 or L>2^AW -> o_err=1, go to IDLE.
  - Otherwise latch L -> DATA.
- DATA: each accepted byte is written to memory at o_count; o_count increments and the byte is XORed into the accumulator. After byte L-1 -> CHECK.
- CHECK: accept C.
  - Match -> RUN.
  - Mismatch -> o_err=1, go to IDLE. Memory keeps the partial image.
- RUN: o_ready=0, o_cpu_run=1. When i_cpu_halt=1 -> IDLE, o_cpu_run=0, o_done pulses for one cycle.
- o_cpu_run is 1 only in RUN.
- o_busy is 1 in LEN/DATA/CHECK.
- Arithmetic: o_count is AW+1 bits wide, so L=32 is representable. The memory address is o_count[AW-1:0]; no wrap occurs within a legal frame.

## Timing
- Reset (rst low, asynchronous): state=IDLE. All outputs 0: o_ready, o_mem_wr, o_mem_addr, o_mem_data, o_cpu_run, o_busy, o_err, o_done, o_count.
  - o_ready goes to 1 on the first clock after reset is deasserted.
  - Reset mid-frame abandons the frame; memory contents are not restored.
- Write latency: a data byte accepted at edge t drives o_mem_wr=1, o_mem_addr and o_mem_data during cycle t..t+1 (registered). The strobe lasts exactly one cycle.
- Throughput: one byte per cycle. Back-to-back i_valid must produce one write per cycle with no bubbles.
- o_ready is a registered function of state and is never dependent on i_valid.
- RUN entry: o_cpu_run rises on the edge that accepts a correct C.
- Halt: i_cpu_halt is sampled each cycle in RUN. The exit edge drops o_cpu_run and raises o_done for one cycle. o_ready returns the cycle after.
- i_cpu_halt is ignored outside RUN.
- A stall (i_valid=0) in any state holds state and the accumulator indefinitely; there is no timeout.

## Structure
- Shared package prog_loader_pkg holds:
  - the state enumeration (IDLE, LEN, DATA, CHECK, RUN)
  - MAGIC default value
  - AW/DW defaults, matching the CPU memory width
- One sub-module, checksum_acc: XOR accumulator with clear and enable inputs and a DW-wide output.
- The write-port output register is kept in the top of the loader.

## Test plan
- Reset, then frame A5,03,11,22,33,00 -> writes 11@0, 22@1, 33@2 on three consecutive cycles; o_cpu_run=1; o_count=3; o_err=0.
- Same frame with C=01 -> three writes occur, o_err=1, o_cpu_run stays 0, state returns to IDLE. The next A5 clears o_err.
- L=00, and separately L=21h (33) -> o_err=1, no writes.
- L=20h (32) with bytes 00..1F and C=00 -> 32 writes to addresses 0..31, o_count=32, RUN entered.
- In RUN, raise i_cpu_halt -> o_cpu_run falls and o_done pulses one cycle; o_ready=0 throughout RUN. Garbage bytes in IDLE (e.g. 00, FF) are discarded.
- Assert rst during DATA after 2 of 4 bytes -> all outputs 0 immediately. A fresh frame after release loads correctly.
